// File: rtl/sram_pkg.sv
// sram_pkg
// Shared types for the sram_bank slice: the two-state controller
// enumeration and the CS/WE/RD command decode used by the bank.
package sram_pkg;

  // Bank controller states: sweeping INIT_VAL into the array, or serving commands
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Decoded front-end command; CMD_COLLIDE is the illegal write+read combination
  typedef enum logic [1:0] {
    CMD_NOP     = 2'd0,
    CMD_WRITE   = 2'd1,
    CMD_READ    = 2'd2,
    CMD_COLLIDE = 2'd3
  } cmd_t;

  // Collapse the three strobes into one command; a deselected bank sees nothing
  function automatic cmd_t decodeCmd(input logic cs, input logic we, input logic rd);
    cmd_t cmd;
    cmd = CMD_NOP;
    if (cs) begin
      unique case ({we, rd})
        2'b10:   cmd = CMD_WRITE;
        2'b01:   cmd = CMD_READ;
        2'b11:   cmd = CMD_COLLIDE;
        default: cmd = CMD_NOP;
      endcase
    end
    return cmd;
  endfunction

endpackage

// File: rtl/sram_core.sv
// sram_core
// Bare DEPTH x DATA_W storage with one shared address, a write port and a
// registered read port. The read register is the only state that resets.
// Ports:
//   Clk    - clock, rising edge
//   Rst    - synchronous active-high reset, zeroes rData only
//   we     - write mem[addr] <= wData
//   re     - load rData <= mem[addr]; rData holds otherwise
//   addr   - word address
//   wData  - write data
//   rData  - registered read data
module sram_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wData,
  output logic [DATA_W-1:0] rData
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage array; contents are initialised by the bank's clear sweep, not by reset
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[addr] <= wData;
    end
  end

  // Read register holds the last value read until the next read or a reset
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rData <= '0;
    end else if (re) begin
      rData <= mem[addr];
    end
  end

endmodule

// File: rtl/sram_bank.sv
// sram_bank
// Single-port synchronous SRAM bank with a hardware clear sequencer,
// registered read data plus valid strobe, ready indication and a sticky
// protocol-error flag for simultaneous write and read.
// Ports:
//   Clk    - clock, rising edge
//   Rst    - synchronous active-high reset; restarts the clear sweep
//   CS     - chip select, commands ignored when low
//   WE     - write enable
//   RD     - read enable
//   ClrReq - request a full-array clear sweep (honoured only when ready)
//   Addr   - word address
//   dataIn - write data
//   Q      - registered read data, holds last read value
//   QValid - one-cycle strobe: Q was updated by a read
//   Ready  - bank accepts commands
//   Err    - sticky protocol error (WE and RD together)
module sram_bank
  import sram_pkg::*;
#(
  parameter int                DATA_W   = 4,
  parameter int                ADDR_W   = 2,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              CS,
  input  logic              WE,
  input  logic              RD,
  input  logic              ClrReq,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] Q,
  output logic              QValid,
  output logic              Ready,
  output logic              Err
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] clrPtr;
  logic [ADDR_W-1:0] nextPtr;
  logic              qValidReg;
  logic              nextQValid;
  logic              errReg;
  logic              nextErr;
  logic              memWe;
  logic              memRe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWData;

  // State, clear pointer and status flags; reset restarts the sweep from word 0
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ST_CLEAR;
      clrPtr    <= '0;
      qValidReg <= 1'b0;
      errReg    <= 1'b0;
    end else begin
      state     <= nextState;
      clrPtr    <= nextPtr;
      qValidReg <= nextQValid;
      errReg    <= nextErr;
    end
  end

  // Next-state and array-port decode. The sweep owns the array port while
  // clearing; in READY a clear request outranks any coincident command.
  always_comb begin
    nextState  = state;
    nextPtr    = clrPtr;
    nextQValid = 1'b0;
    nextErr    = errReg;
    memWe      = 1'b0;
    memRe      = 1'b0;
    memAddr    = Addr;
    memWData   = dataIn;
    unique case (state)
      ST_CLEAR: begin
        memWe    = 1'b1;
        memAddr  = clrPtr;
        memWData = INIT_VAL;
        nextPtr  = clrPtr + ADDR_W'(1);
        if (clrPtr == LAST_PTR) begin
          nextState = ST_READY;
        end
      end
      ST_READY: begin
        if (ClrReq) begin
          nextState = ST_CLEAR;
          nextPtr   = '0;
        end else begin
          unique case (decodeCmd(CS, WE, RD))
            CMD_WRITE: memWe = 1'b1;
            CMD_READ: begin
              memRe      = 1'b1;
              nextQValid = 1'b1;
            end
            CMD_COLLIDE: nextErr = 1'b1;
            default: ;
          endcase
        end
      end
      default: nextState = ST_CLEAR;
    endcase
  end

  // A reset edge must not disturb the array even though the comb decode may request a write
  sram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) uCore (
    .Clk  (Clk),
    .Rst  (Rst),
    .we   (memWe & ~Rst),
    .re   (memRe),
    .addr (memAddr),
    .wData(memWData),
    .rData(Q)
  );

  assign QValid = qValidReg;
  assign Ready  = (state == ST_READY);
  assign Err    = errReg;

endmodule

// File: tb/tb_sram_bank.sv
// tb_sram_bank
// Two 4-bit banks (INIT_VAL 0 and 3) share one stimulus stream driven from a
// vector table; a 16-bit, 16-deep bank is exercised by a hand-written sequence.
module tb_sram_bank;

  logic       Clk;
  logic       Rst;
  logic       CS, WE, RD, ClrReq;
  logic [1:0] Addr;
  logic [3:0] dataIn;
  logic [3:0] qA, qB;
  logic       qValidA, qValidB, readyA, readyB, errA, errB;

  logic        RstC;
  logic        csC, weC, rdC, clrC;
  logic [3:0]  addrC;
  logic [15:0] dinC;
  logic [15:0] qC;
  logic        qValidC, readyC, errC;

  int nChecks;
  int nFail;

  sram_bank #(.DATA_W(4), .ADDR_W(2), .INIT_VAL(4'h0)) dutA (
    .Clk(Clk), .Rst(Rst), .CS(CS), .WE(WE), .RD(RD), .ClrReq(ClrReq),
    .Addr(Addr), .dataIn(dataIn), .Q(qA), .QValid(qValidA), .Ready(readyA), .Err(errA)
  );

  sram_bank #(.DATA_W(4), .ADDR_W(2), .INIT_VAL(4'h3)) dutB (
    .Clk(Clk), .Rst(Rst), .CS(CS), .WE(WE), .RD(RD), .ClrReq(ClrReq),
    .Addr(Addr), .dataIn(dataIn), .Q(qB), .QValid(qValidB), .Ready(readyB), .Err(errB)
  );

  sram_bank #(.DATA_W(16), .ADDR_W(4), .INIT_VAL(16'h0000)) dutC (
    .Clk(Clk), .Rst(RstC), .CS(csC), .WE(weC), .RD(rdC), .ClrReq(clrC),
    .Addr(addrC), .dataIn(dinC), .Q(qC), .QValid(qValidC), .Ready(readyC), .Err(errC)
  );

  // Free-running clock
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  typedef struct {
    logic       clr, cs, we, rd;
    logic [1:0] addr;
    logic [3:0] din;
    logic [3:0] expQA, expQB;
    logic       expQv, expRdy, expErr;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic clr, input logic cs, input logic we, input logic rd,
                              input logic [1:0] addr, input logic [3:0] din,
                              input logic [3:0] qa, input logic [3:0] qb,
                              input logic qv, input logic rdy, input logic err);
    vec_t v;
    v.clr = clr; v.cs = cs; v.we = we; v.rd = rd; v.addr = addr; v.din = din;
    v.expQA = qa; v.expQB = qb; v.expQv = qv; v.expRdy = rdy; v.expErr = err;
    return v;
  endfunction

  task automatic applyStimulus(input logic clr, input logic cs, input logic we, input logic rd,
                               input logic [1:0] addr, input logic [3:0] din);
    ClrReq = clr; CS = cs; WE = we; RD = rd; Addr = addr; dataIn = din;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Compare both 4-bit banks; only Q differs between them
  task automatic checkBoth(input string tag, input logic [3:0] qa, input logic [3:0] qb,
                           input logic qv, input logic rdy, input logic err);
    checkOutput({tag, " Q_A"}, {12'h0, qA}, {12'h0, qa});
    checkOutput({tag, " Q_B"}, {12'h0, qB}, {12'h0, qb});
    checkOutput({tag, " QValid_A"}, {15'h0, qValidA}, {15'h0, qv});
    checkOutput({tag, " QValid_B"}, {15'h0, qValidB}, {15'h0, qv});
    checkOutput({tag, " Ready_A"}, {15'h0, readyA}, {15'h0, rdy});
    checkOutput({tag, " Ready_B"}, {15'h0, readyB}, {15'h0, rdy});
    checkOutput({tag, " Err_A"}, {15'h0, errA}, {15'h0, err});
    checkOutput({tag, " Err_B"}, {15'h0, errB}, {15'h0, err});
  endtask

  task automatic checkC(input string tag, input logic [15:0] q, input logic qv, input logic rdy);
    checkOutput({tag, " Q_C"}, qC, q);
    checkOutput({tag, " QValid_C"}, {15'h0, qValidC}, {15'h0, qv});
    checkOutput({tag, " Ready_C"}, {15'h0, readyC}, {15'h0, rdy});
    checkOutput({tag, " Err_C"}, {15'h0, errC}, 16'h0);
  endtask

  task automatic stepC(input logic cs, input logic we, input logic rd,
                       input logic [3:0] addr, input logic [15:0] din);
    csC = cs; weC = we; rdC = rd; addrC = addr; dinC = din;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    nChecks = 0;
    nFail   = 0;
    // Each entry: inputs before an edge, outputs expected just after it.
    // Edges 1-4 are the initial sweep; the read at edge 4 is ignored.
    //            clr cs we rd addr din    qA    qB   qv rdy err
    vecs[0]  = mk(0, 0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 2'd0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 0, 1, 2'd0, 4'h0, 4'h0, 4'h0, 0, 1, 0);
    vecs[4]  = mk(0, 1, 0, 1, 2'd0, 4'h0, 4'h0, 4'h3, 1, 1, 0);
    vecs[5]  = mk(0, 1, 0, 1, 2'd1, 4'h0, 4'h0, 4'h3, 1, 1, 0);
    vecs[6]  = mk(0, 1, 0, 1, 2'd2, 4'h0, 4'h0, 4'h3, 1, 1, 0);
    vecs[7]  = mk(0, 1, 0, 1, 2'd3, 4'h0, 4'h0, 4'h3, 1, 1, 0);
    vecs[8]  = mk(0, 1, 1, 0, 2'd2, 4'hA, 4'h0, 4'h3, 0, 1, 0);
    vecs[9]  = mk(0, 1, 0, 1, 2'd2, 4'h0, 4'hA, 4'hA, 1, 1, 0);
    vecs[10] = mk(0, 1, 0, 1, 2'd1, 4'h0, 4'h0, 4'h3, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 2'd1, 4'h0, 4'h0, 4'h3, 0, 1, 0);
    vecs[12] = mk(0, 1, 1, 1, 2'd1, 4'hF, 4'h0, 4'h3, 0, 1, 1);
    vecs[13] = mk(0, 0, 0, 0, 2'd1, 4'h0, 4'h0, 4'h3, 0, 1, 1);
    vecs[14] = mk(0, 1, 0, 1, 2'd1, 4'h0, 4'h0, 4'h3, 1, 1, 1);
    vecs[15] = mk(0, 1, 1, 0, 2'd0, 4'h5, 4'h0, 4'h3, 0, 1, 1);
    vecs[16] = mk(0, 1, 1, 0, 2'd3, 4'h6, 4'h0, 4'h3, 0, 1, 1);
    vecs[17] = mk(0, 1, 0, 1, 2'd3, 4'h0, 4'h6, 4'h6, 1, 1, 1);
    // Clear request with a coincident read; sweep runs edges 20..23
    vecs[18] = mk(1, 1, 0, 1, 2'd0, 4'h0, 4'h6, 4'h6, 0, 0, 1);
    vecs[19] = mk(0, 1, 1, 0, 2'd0, 4'hF, 4'h6, 4'h6, 0, 0, 1);
    vecs[20] = mk(0, 1, 0, 1, 2'd0, 4'h0, 4'h6, 4'h6, 0, 0, 1);
    vecs[21] = mk(1, 0, 0, 0, 2'd0, 4'h0, 4'h6, 4'h6, 0, 0, 1);
    vecs[22] = mk(0, 1, 1, 0, 2'd3, 4'h9, 4'h6, 4'h6, 0, 1, 1);
    vecs[23] = mk(0, 1, 0, 1, 2'd0, 4'h0, 4'h0, 4'h3, 1, 1, 1);
    vecs[24] = mk(0, 1, 0, 1, 2'd3, 4'h0, 4'h0, 4'h3, 1, 1, 1);
    vecs[25] = mk(0, 1, 0, 1, 2'd2, 4'h0, 4'h0, 4'h3, 1, 1, 1);

    Rst  = 1'b1;
    RstC = 1'b1;
    applyStimulus(0, 0, 0, 0, 2'd0, 4'h0);
    csC = 0; weC = 0; rdC = 0; clrC = 0; addrC = '0; dinC = '0;

    @(posedge Clk);
    #1;
    checkBoth("reset", 4'h0, 4'h0, 0, 0, 0);
    Rst = 1'b0;

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].cs, vecs[i].we, vecs[i].rd, vecs[i].addr, vecs[i].din);
      @(posedge Clk);
      #1;
      checkBoth($sformatf("vec%0d", i), vecs[i].expQA, vecs[i].expQB,
                vecs[i].expQv, vecs[i].expRdy, vecs[i].expErr);
    end

    // Start a sweep, reset two cycles into it
    applyStimulus(1, 0, 0, 0, 2'd0, 4'h0);
    @(posedge Clk);
    #1;
    checkBoth("sweepStart", 4'h0, 4'h3, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 2'd0, 4'h0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    checkBoth("midSweepRst", 4'h0, 4'h0, 0, 0, 0);
    Rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge Clk);
      #1;
      checkBoth($sformatf("postRst%0d", k), 4'h0, 4'h0, 0, (k == 4), 0);
    end
    applyStimulus(0, 1, 0, 1, 2'd1, 4'h0);
    @(posedge Clk);
    #1;
    checkBoth("postRstRead", 4'h0, 4'h3, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 2'd0, 4'h0);

    // Wide, deep bank: 16-cycle sweep then a few accesses
    @(posedge Clk);
    #1;
    checkC("resetC", 16'h0000, 0, 0);
    RstC = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge Clk);
      #1;
      checkOutput($sformatf("sweepC%0d Ready_C", k), {15'h0, readyC}, {15'h0, (k == 16)});
    end
    stepC(1, 1, 0, 4'd15, 16'hBEEF);
    checkC("wrC15", 16'h0000, 0, 1);
    stepC(1, 1, 0, 4'd0, 16'h1234);
    checkC("wrC0", 16'h0000, 0, 1);
    stepC(0, 1, 0, 4'd15, 16'h0000);
    checkC("csLowWr", 16'h0000, 0, 1);
    stepC(0, 0, 1, 4'd0, 16'h0000);
    checkC("csLowRd", 16'h0000, 0, 1);
    stepC(1, 0, 1, 4'd15, 16'h0000);
    checkC("rdC15", 16'hBEEF, 1, 1);
    stepC(1, 0, 1, 4'd0, 16'h0000);
    checkC("rdC0", 16'h1234, 1, 1);
    stepC(1, 0, 1, 4'd5, 16'h0000);
    checkC("rdC5", 16'h0000, 1, 1);
    stepC(0, 0, 0, 4'd0, 16'h0000);
    checkC("idleC", 16'h0000, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
